// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: fetches a block-aligned line beat by beat from IRAM and writes it to the cache.
// Optional performance counters (miss_cnt, refill_cyc) are enabled by defining ICACHE_REFILL_PERF_EN.
module icache_refill_ctrl #(
    parameter int unsigned BLOCK_BITS = 128,
    parameter int unsigned PC_BITS    = 32
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 fetch_req,
    input  logic [PC_BITS-1:0]   pc,
    input  logic                 hit,
    output logic                 stall,
    output logic                 mem_req,
    output logic [PC_BITS-1:0]   mem_addr,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_rdata,
    output logic                 cache_we,
    output logic [0:BLOCK_BITS-1] block_out
`ifdef ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0]          miss_cnt,
    output logic [31:0]          refill_cyc
`endif
);

    localparam int unsigned NBEATS = BLOCK_BITS / 32;
    localparam int unsigned BEAT_W = $clog2(NBEATS);
    localparam int unsigned OFF_W  = $clog2(BLOCK_BITS / 8);
    localparam int unsigned LINE_W = PC_BITS - OFF_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic [0:BLOCK_BITS-1]   buf_q, buf_d;

    // Byte offset bits of pc never reach the line address.
    logic unused_pc_bits;
    assign unused_pc_bits = ^pc[OFF_W-1:0];

    // Next-state logic; each beat's bytes land at ascending indices, byte MSB at the lowest index.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        line_d  = line_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (fetch_req && !hit) begin
                    line_d  = pc[PC_BITS-1:OFF_W];
                    beat_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    for (int unsigned k = 0; k < NBEATS; k++) begin
                        if (beat_q == BEAT_W'(k)) begin
                            for (int unsigned b = 0; b < 4; b++) begin
                                buf_d[32*k+8*b +: 8] = mem_rdata[8*b +: 8];
                            end
                        end
                    end
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(NBEATS - 1)) begin
                        state_d = FILL;
                    end
                end
            end
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            line_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            buf_q   <= buf_d;
        end
    end

    // Stall in IDLE is the raw miss; gated by nrst so reset forces it low immediately.
    assign stall     = nrst && (((state_q == IDLE) && fetch_req && !hit) || (state_q == FETCH));
    assign mem_req   = (state_q == FETCH);
    assign mem_addr  = {line_q, beat_q, 2'b00};
    assign cache_we  = (state_q == FILL);
    assign block_out = buf_q;

`ifdef ICACHE_REFILL_PERF_EN
    logic miss_start;
    assign miss_start = (state_q == IDLE) && (state_d == FETCH);

    // Saturating miss and busy-cycle counters.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            miss_cnt   <= '0;
            refill_cyc <= '0;
        end else begin
            if (miss_start && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
            if (((state_q == FETCH) || (state_q == FILL)) && (refill_cyc != 32'hFFFF_FFFF)) begin
                refill_cyc <= refill_cyc + 32'd1;
            end
        end
    end
`endif

endmodule
